// File: rtl/mu0_cpu_delay1_if.sv
// Single-port RAM bus shared by MU0 instruction fetch and data access.
// The CPU is the master; the RAM answers reads one cycle later on readdata.
interface mu0_cpu_delay1_if;
    logic [11:0] address;
    logic        write;
    logic        read;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output write,
        output read,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  read,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/mu0_cpu_delay1.sv
// Multicycle MU0 core: FETCH / DECODE / EXEC / HALTED over a single RAM port,
// absorbing the RAM's one-cycle read latency by decoding straight off readdata.
module mu0_cpu_delay1 #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst,
    mu0_cpu_delay1_if.master      bus,
    output logic                  running,
    output logic [11:0]           pc_dbg,
    output logic [15:0]           acc_dbg
);

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [ADDR_W-1:0]         pc;
    logic signed [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]         ir;

    logic [3:0]                dec_op;
    logic [ADDR_W-1:0]         dec_s;
    logic [3:0]                ir_op;
    logic [ADDR_W-1:0]         ir_s;

    assign dec_op = bus.readdata[15:12];
    assign dec_s  = bus.readdata[11:0];
    assign ir_op  = ir[15:12];
    assign ir_s   = ir[11:0];

    assign pc_dbg  = pc;
    assign acc_dbg = acc;

    // 16-bit wrapping ALU; LDA simply passes the operand through.
    function automatic logic signed [DATA_W-1:0] alu(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            default: alu = b;
        endcase
    endfunction

    function automatic logic branch_taken(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a
    );
        case (op)
            OP_JMP:  branch_taken = 1'b1;
            OP_JGE:  branch_taken = (a >= 0);
            OP_JNE:  branch_taken = (a != 0);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    function automatic logic needs_operand(input logic [3:0] op);
        needs_operand = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (needs_operand(dec_op)) begin
                    next_state = EXEC;
                end else if (dec_op == OP_STO || dec_op == OP_JMP ||
                             dec_op == OP_JGE || dec_op == OP_JNE) begin
                    next_state = FETCH;
                end else begin
                    next_state = HALTED;
                end
            end
            EXEC:    next_state = FETCH;
            HALTED:  next_state = HALTED;
            default: next_state = FETCH;
        endcase
    end

    // Reset forces the bus quiet regardless of state, so an aborted STO never writes.
    always_comb begin
        running       = 1'b0;
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        if (!rst) begin
            running = (state != HALTED);
            case (state)
                FETCH: begin
                    bus.address = pc;
                    bus.read    = 1'b1;
                end
                DECODE: begin
                    if (needs_operand(dec_op)) begin
                        bus.address = dec_s;
                        bus.read    = 1'b1;
                    end else if (dec_op == OP_STO) begin
                        bus.address   = dec_s;
                        bus.write     = 1'b1;
                        bus.writedata = acc;
                    end
                end
                EXEC: begin
                    bus.address = ir_s;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_PC;
            acc <= '0;
            ir  <= '0;
        end else begin
            case (state)
                FETCH: pc <= pc + 12'd1;
                DECODE: begin
                    ir <= bus.readdata;
                    if (branch_taken(dec_op, acc)) begin
                        pc <= dec_s;
                    end
                end
                EXEC: acc <= alu(ir_op, acc, $signed(bus.readdata));
                default: ;
            endcase
        end
    end

endmodule
